vector_frame_reducer: RTL and testbench

Downstream consumer of the input buffer's dequeue stream. Reduces each N-lane vector to one signed scalar (sum, max or min, selected per chain by firmware), accumulates it across a frame delimited by bof/eof, and emits one scalar plus a vector count per chain per frame. Per-chain state lets the chain-interleaved stream from the input buffer be processed without stalls.

---
 rtl/vector_frame_reducer.sv | 208 ++++++++++++++++++++
 tb/tb_vector_frame_reducer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vector_frame_reducer.sv
// Per-chain frame reducer: each N-lane vector is folded to one signed scalar (sum/max/min),
// then accumulated across a bof..eof frame. One result pulse per frame, three-stage pipeline.

module vfr_reduce_node #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_y
);
    always_comb begin
        case (i_op)
            2'd1:    o_y = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
            2'd2:    o_y = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
            default: o_y = i_a + i_b;
        endcase
    end
endmodule

module vector_frame_reducer #(
    parameter int         N                = 8,
    parameter int         DATA_WIDTH       = 32,
    parameter int         MAX_CHAINS       = 4,
    parameter int         REDUCE_CONFIG_ID = 2,
    parameter logic [7:0] INITIAL_FIRMWARE = 8'hFF,
    localparam int        CW               = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            configId,
    input  logic [7:0]            configData,
    input  logic                  valid_in,
    input  logic                  bof_in,
    input  logic                  eof_in,
    input  logic [CW-1:0]         chainId_in,
    input  logic [DATA_WIDTH-1:0] vector_in [N-1:0],
    output logic                  valid_out,
    output logic [CW-1:0]         chainId_out,
    output logic [DATA_WIDTH-1:0] scalar_out,
    output logic [15:0]           count_out
);
    localparam int LG = $clog2(N);

    logic [7:0]            r_op_reg;
    logic [MAX_CHAINS-1:0] r_open;
    logic [1:0]            r_lop [MAX_CHAINS];
    logic [2:0]            r_vld_pipe;

    logic                  w_chain_ok;
    logic [1:0]            w_fw_op;
    logic                  w_opens;
    logic [1:0]            w_op;
    logic                  w_beat;
    logic                  w_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_op_reg <= INITIAL_FIRMWARE;
        else if (configId == 8'(REDUCE_CONFIG_ID)) r_op_reg <= configData;
    end

    if (MAX_CHAINS == (1 << CW)) begin : g_ok_all
        assign w_chain_ok = 1'b1;
    end else begin : g_ok_cmp
        assign w_chain_ok = (32'(chainId_in) < MAX_CHAINS);
    end

    // Frame open/closed and the latched op are tracked at the input so stage 1
    // already knows which op to apply to this beat's lane tree.
    assign w_fw_op = r_op_reg[{chainId_in, 1'b0} +: 2];
    assign w_opens = bof_in | ~r_open[chainId_in];
    assign w_op    = w_opens ? w_fw_op : r_lop[chainId_in];
    assign w_beat  = valid_in & w_chain_ok;
    assign w_take  = w_beat & (w_op != 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_open <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) r_lop[c] <= 2'd0;
        end else if (w_beat) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                if (chainId_in == CW'(c)) begin
                    if (w_op == 2'd3) begin
                        r_open[c] <= 1'b0;
                    end else begin
                        r_open[c] <= ~eof_in;
                        if (w_opens) r_lop[c] <= w_op;
                    end
                end
            end
        end
    end

    genvar l, i;
    for (l = 0; l <= LG; l++) begin : g_lvl
        logic [DATA_WIDTH-1:0] w_node [(N >> l)];
        if (l == 0) begin : g_leaf
            for (i = 0; i < N; i++) begin : g_l
                assign w_node[i] = vector_in[i];
            end
        end else begin : g_red
            for (i = 0; i < (N >> l); i++) begin : g_n
                vfr_reduce_node #(.DATA_WIDTH(DATA_WIDTH)) u_node (
                    .i_op (w_op),
                    .i_a  (g_lvl[l-1].w_node[2*i]),
                    .i_b  (g_lvl[l-1].w_node[2*i+1]),
                    .o_y  (w_node[i])
                );
            end
        end
    end

    logic [CW-1:0]         r1_chain;
    logic                  r1_first;
    logic                  r1_eof;
    logic [1:0]            r1_op;
    logic [DATA_WIDTH-1:0] r1_scalar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_chain  <= '0;
            r1_first  <= 1'b0;
            r1_eof    <= 1'b0;
            r1_op     <= 2'd0;
            r1_scalar <= '0;
        end else if (w_take) begin
            r1_chain  <= chainId_in;
            r1_first  <= w_opens;
            r1_eof    <= eof_in;
            r1_op     <= w_op;
            r1_scalar <= g_lvl[LG].w_node[0];
        end
    end

    logic [DATA_WIDTH-1:0] r_acc [MAX_CHAINS];
    logic [15:0]           r_cnt [MAX_CHAINS];
    logic [DATA_WIDTH-1:0] w_acc_old;
    logic [DATA_WIDTH-1:0] w_acc_comb;
    logic [DATA_WIDTH-1:0] w_acc_new;
    logic [15:0]           w_cnt_old;
    logic [15:0]           w_cnt_new;

    assign w_acc_old = r_acc[r1_chain];
    assign w_cnt_old = r_cnt[r1_chain];

    vfr_reduce_node #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
        .i_op (r1_op),
        .i_a  (w_acc_old),
        .i_b  (r1_scalar),
        .o_y  (w_acc_comb)
    );

    assign w_acc_new = r1_first ? r1_scalar : w_acc_comb;
    assign w_cnt_new = r1_first ? 16'd1 :
                       (w_cnt_old == 16'hFFFF) ? w_cnt_old : w_cnt_old + 16'd1;

    logic [CW-1:0]         r2_chain;
    logic [DATA_WIDTH-1:0] r2_scalar;
    logic [15:0]           r2_cnt;
    logic [CW-1:0]         r_out_chain;
    logic [DATA_WIDTH-1:0] r_out_scalar;
    logic [15:0]           r_out_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                r_acc[c] <= '0;
                r_cnt[c] <= '0;
            end
            r2_chain     <= '0;
            r2_scalar    <= '0;
            r2_cnt       <= '0;
            r_out_chain  <= '0;
            r_out_scalar <= '0;
            r_out_cnt    <= '0;
        end else begin
            r_vld_pipe[0] <= w_take;
            r_vld_pipe[1] <= r_vld_pipe[0] & r1_eof;
            r_vld_pipe[2] <= r_vld_pipe[1];
            if (r_vld_pipe[0]) begin
                for (int c = 0; c < MAX_CHAINS; c++) begin
                    if (r1_chain == CW'(c)) begin
                        r_acc[c] <= w_acc_new;
                        r_cnt[c] <= w_cnt_new;
                    end
                end
            end
            if (r_vld_pipe[0] && r1_eof) begin
                r2_chain  <= r1_chain;
                r2_scalar <= w_acc_new;
                r2_cnt    <= w_cnt_new;
            end
            // Output fields only move on a pulse, so they hold between frames.
            if (r_vld_pipe[1]) begin
                r_out_chain  <= r2_chain;
                r_out_scalar <= r2_scalar;
                r_out_cnt    <= r2_cnt;
            end
        end
    end

    assign valid_out   = r_vld_pipe[2];
    assign chainId_out = r_out_chain;
    assign scalar_out  = r_out_scalar;
    assign count_out   = r_out_cnt;

endmodule

// File: tb/tb_vector_frame_reducer.sv
// Directed per-cycle vector table for vector_frame_reducer, plus hand sequences for reset recovery.

module tb_vector_frame_reducer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  configId, configData;
    logic        valid_in, bof_in, eof_in;
    logic [1:0]  chainId_in;
    logic [31:0] vec [7:0];
    logic        valid_out;
    logic [1:0]  chainId_out;
    logic [31:0] scalar_out;
    logic [15:0] count_out;

    vector_frame_reducer dut (
        .clk(clk), .rst_n(rst_n), .configId(configId), .configData(configData),
        .valid_in(valid_in), .bof_in(bof_in), .eof_in(eof_in), .chainId_in(chainId_in),
        .vector_in(vec), .valid_out(valid_out), .chainId_out(chainId_out),
        .scalar_out(scalar_out), .count_out(count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  cfg;
        logic        v, b, e;
        logic [1:0]  ch;
        logic [1:0]  pat;   // 0: ramp base+j, 1: all base, 2: lane0=base, rest 7
        int          base;
        logic        ev;
        logic [1:0]  ech;
        logic [31:0] esc;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   row      = -1;

    task automatic add(input logic we, input logic [7:0] cfg, input logic v, b, e,
                       input logic [1:0] ch, input logic [1:0] pat, input int base,
                       input logic ev, input logic [1:0] ech, input int esc, input int ecnt);
        vec_t r;
        r.we = we; r.cfg = cfg; r.v = v; r.b = b; r.e = e; r.ch = ch; r.pat = pat;
        r.base = base; r.ev = ev; r.ech = ech; r.esc = 32'(esc); r.ecnt = 16'(ecnt);
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] cfg, input logic v, b, e,
                         input logic [1:0] ch, input logic [1:0] pat, input int base);
        configId   = we ? 8'd2 : 8'd0;
        configData = cfg;
        valid_in   = v;
        bof_in     = b;
        eof_in     = e;
        chainId_in = ch;
        for (int j = 0; j < 8; j++) begin
            case (pat)
                2'd0:    vec[j] = 32'(base + j);
                2'd1:    vec[j] = 32'(base);
                default: vec[j] = (j == 0) ? 32'(base) : 32'd7;
            endcase
        end
    endtask

    task automatic chk_out(input logic ev, input logic [1:0] ech, input logic [31:0] esc,
                           input logic [15:0] ecnt);
        chk("valid_out", 32'(valid_out), 32'(ev));
        chk("chainId_out", 32'(chainId_out), 32'(ech));
        chk("scalar_out", scalar_out, esc);
        chk("count_out", 32'(count_out), 32'(ecnt));
    endtask

    initial begin
        //   we cfg    v b e ch pat base          ev ch esc          cnt
        add(1, 8'hFC, 0,0,0, 0, 0, 0,            0, 0, 0,           0);
        add(0, 8'h00, 1,1,0, 0, 0, 1,            0, 0, 0,           0);
        add(0, 8'h00, 1,0,0, 0, 0, 1,            0, 0, 0,           0);
        add(0, 8'h00, 1,0,1, 0, 0, 1,            0, 0, 0,           0);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            0, 0, 0,           0);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            1, 0, 108,         3);
        add(1, 8'hF9, 0,0,0, 0, 0, 0,            0, 0, 108,         3);
        add(0, 8'h00, 1,1,0, 0, 0, -5,           0, 0, 108,         3);
        add(0, 8'h00, 1,1,0, 1, 2, -100,         0, 0, 108,         3);
        add(0, 8'h00, 1,0,1, 0, 0, -5,           0, 0, 108,         3);
        add(0, 8'h00, 1,0,1, 1, 2, -50,          0, 0, 108,         3);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            1, 0, 2,           2);
        add(1, 8'hFC, 0,0,0, 0, 0, 0,            1, 1, -100,        2);
        add(0, 8'h00, 1,1,1, 0, 1, 32'h7FFFFFFF, 0, 1, -100,        2);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            0, 1, -100,        2);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            1, 0, 32'hFFFFFFF8, 1);
        add(0, 8'h00, 1,1,0, 0, 0, 1,            0, 0, 32'hFFFFFFF8, 1);
        add(1, 8'hFD, 1,0,0, 0, 0, 1,            0, 0, 32'hFFFFFFF8, 1);
        add(0, 8'h00, 1,0,1, 0, 0, 1,            0, 0, 32'hFFFFFFF8, 1);
        add(0, 8'h00, 1,1,0, 0, 0, 10,           0, 0, 32'hFFFFFFF8, 1);
        add(0, 8'h00, 1,0,1, 0, 0, 10,           1, 0, 108,         3);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            0, 0, 108,         3);
        add(1, 8'hFC, 0,0,0, 0, 0, 0,            1, 0, 17,          2);
        add(0, 8'h00, 1,1,1, 0, 0, 1,            0, 0, 17,          2);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            0, 0, 17,          2);
        add(0, 8'h00, 1,1,0, 0, 0, 1,            1, 0, 36,          1);
        add(0, 8'h00, 1,1,0, 0, 0, 1,            0, 0, 36,          1);
        add(0, 8'h00, 1,0,1, 0, 0, 1,            0, 0, 36,          1);
        add(0, 8'h00, 1,1,0, 2, 0, 1,            0, 0, 36,          1);
        add(0, 8'h00, 1,0,1, 2, 0, 1,            1, 0, 72,          2);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            0, 0, 72,          2);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            0, 0, 72,          2);
        add(0, 8'h00, 1,0,1, 0, 0, 2,            0, 0, 72,          2);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            0, 0, 72,          2);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            1, 0, 44,          1);
        add(0, 8'h00, 0,0,0, 0, 0, 0,            0, 0, 44,          1);

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_out(0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].we, tbl[k].cfg, tbl[k].v, tbl[k].b, tbl[k].e, tbl[k].ch, tbl[k].pat, tbl[k].base);
            @(posedge clk); #1;
            row = k;
            chk_out(tbl[k].ev, tbl[k].ech, tbl[k].esc, tbl[k].ecnt);
        end

        // Reset in the middle of an open chain0 frame.
        row = 100;
        @(negedge clk); drive(0, 8'h00, 1, 1, 0, 0, 0, 1);
        @(negedge clk); drive(0, 8'h00, 0, 0, 0, 0, 0, 0); rst_n = 1'b0;
        #1 chk_out(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            row = 101 + c;
            chk("post_rst_valid", 32'(valid_out), 32'd0);
        end
        @(negedge clk); drive(1, 8'hFC, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 8'h00, 1, 0, 1, 0, 0, 1);
        @(posedge clk); #1;
        @(negedge clk); drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        row = 110;
        chk("recov_early", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        row = 111;
        chk_out(1, 0, 36, 1);
        @(posedge clk); #1;
        row = 112;
        chk_out(0, 0, 36, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
